// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one FP add/sub unit among NREQ requesters.
// Ports: req_* (per-requester handshake/operands), rsp_* (one-hot response
// with result/err), fu_* (launch, operands, completion from the FP unit).
// Optional: define FP_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles.
module fp_addsub_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 fu_start,
  output logic [31:0]          fu_a,
  output logic [31:0]          fu_b,
  input  logic                 fu_done,
  input  logic [31:0]          fu_result
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad
    $error("fp_addsub_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   pick;
  logic            found;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     res_q, res_d;
  logic            start_q, start_d;
  logic [31:0]     sel_a, sel_b;
  logic            tmo;

  // Round-robin search begins one past the last served requester.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  assign sel_a = req_a[32*int'(own_q) +: 32];
  assign sel_b = req_b[32*int'(own_q) +: 32];

`ifdef FP_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  assign cnt_d = (state_q == S_WAIT) ? cnt_q + 8'd1 : 8'd0;
  assign tmo   = (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q & (state_q == S_RESP);
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    start_d = 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          own_d   = pick;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A request withdrawn during the grant cycle is dropped.
        if (req_valid[own_q]) begin
          a_d     = sel_a;
          b_d     = req_sub[own_q] ?
                    {~sel_b[31], sel_b[30:0]} : sel_b;
          start_d = 1'b1;
          state_d = S_WAIT;
`ifdef FP_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (fu_done) begin
          res_d   = fu_result;
          state_d = S_RESP;
        end else if (tmo) begin
          res_d   = 32'h7FC0_0000;
          state_d = S_RESP;
`ifdef FP_ARB_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      S_RESP: begin
        last_d  = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      own_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      start_q <= start_d;
    end
  end

  assign req_ready = (state_q == S_ISSUE) ?
                     (NREQ'(1) << own_q) : '0;
  assign rsp_valid = (state_q == S_RESP) ?
                     (NREQ'(1) << own_q) : '0;
  assign fu_start  = start_q;

  // Data outputs read as zero for as long as reset is held.
  assign fu_a      = rst ? '0 : a_q;
  assign fu_b      = rst ? '0 : b_q;
  assign rsp_data  = rst ? '0 : res_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Scoreboard bench for fp_addsub_arbiter: random requesters, a behavioural
// FP-unit model, and a monitor predicting grants round-robin.
module tb_fp_addsub_arbiter;

  localparam int N = 4;
`ifdef FP_ARB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 32;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_sub, rsp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_data, fu_a, fu_b, fu_result;
  logic            rsp_err, fu_start, fu_done;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.NREQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b),
    .fu_done(fu_done), .fu_result(fu_result)
  );

  typedef struct {
    int          own;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] d;
    logic        err;
  } op_t;

  op_t iq[$];
  op_t eq[$];
  int  glog[$];
  int  rcyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt[N];
  int seen[N];
  int kick_req = 0, kick_ack = 0;
  int fcnt = -1;
  int st_cyc = 0, st_n = 0, rsp_n = 0;
  int lat = 0;
  bit lat_rand = 0, mute = 0, hold = 0;
  logic [N-1:0] en;
  logic [N-1:0] last_rv;
  logic [31:0]  last_rd, last_fb, fres;
  logic         last_re;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] fu_fn(input logic [31:0] x,
                                        input logic [31:0] y);
    if (x == 32'h4040_0000 && y == 32'hBF80_0000) return 32'h4000_0000;
    return x ^ {y[15:0], y[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Monitor: grant prediction and response scoreboard.
  int           m_last = N - 1;
  int           mw;
  logic [N-1:0] pv = '0, pr = '0;
  op_t          mo, me;

  always @(negedge clk) begin
    if (rst) begin
      m_last = N - 1;
      pv = '0;
      pr = '0;
    end else begin
      if (req_ready != '0) begin
        mw = rr(pv, m_last);
        chk("grant", 32'(req_ready), (mw < 0) ? 32'd0 : 32'd1 << mw);
        chk("grant_once", 32'(pr), 32'd0);
        if (mw >= 0 && req_valid[mw]) begin
          mo.own = mw;
          mo.a   = req_a[32*mw +: 32];
          mo.b   = req_b[32*mw +: 32];
          mo.sub = req_sub[mw];
          mo.d   = '0;
          mo.err = 1'b0;
          iq.push_back(mo);
          hs_cnt[mw]++;
          glog.push_back(mw);
        end
      end
      if (rsp_valid != '0) begin
        rsp_n++;
        if (eq.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          me = eq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'd1 << me.own);
          chk("rsp_data", rsp_data, me.d);
          chk("rsp_err", 32'(rsp_err), 32'(me.err));
          if (me.err) chk("tmo_latency", cyc - st_cyc, TMO);
          m_last = me.own;
          rcyc.push_back(cyc);
          last_rv = rsp_valid;
          last_rd = rsp_data;
          last_re = rsp_err;
        end
      end
      pv = req_valid;
      pr = req_ready;
    end
  end

  // Behavioural FP unit: checks operands, answers after a latency.
  op_t fo;
  logic [31:0] exp_b;

  initial begin
    fu_done   = 1'b0;
    fu_result = '0;
    forever begin
      @(negedge clk);
      fu_done = 1'b0;
      if (kick_req != kick_ack) begin
        kick_ack  = kick_req;
        fu_done   = 1'b1;
        fu_result = 32'hDEAD_BEEF;
      end
      if (!rst && fu_start) begin
        if (iq.size() == 0) begin
          fail("fu_start_unexpected");
        end else begin
          fo = iq.pop_front();
          exp_b = fo.sub ? {~fo.b[31], fo.b[30:0]} : fo.b;
          chk("fu_a", fu_a, fo.a);
          chk("fu_b", fu_b, exp_b);
          last_fb = fu_b;
          fres   = fu_fn(fo.a, exp_b);
          fo.d   = mute ? 32'h7FC0_0000 : fres;
          fo.err = mute;
          eq.push_back(fo);
          st_cyc = cyc;
          st_n++;
          fcnt = mute ? -1 : (lat_rand ? int'($urandom_range(0, 4)) : lat);
        end
      end
      if (fcnt == 0) begin
        if (eq.size() > 0) chk("fu_a_held", fu_a, fo.a);
        fu_done   = 1'b1;
        fu_result = fres;
        fcnt      = -1;
      end else if (fcnt > 0) begin
        fcnt--;
      end
    end
  end

  // Requester driver, one cycle per call.
  task automatic step();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) begin
      if (hs_cnt[i] != seen[i]) begin
        seen[i] = hs_cnt[i];
        req_valid[i] = 1'b0;
      end
      if (!req_valid[i] && en[i] && (hold || $urandom_range(0, 3) == 0)) begin
        req_valid[i] = 1'b1;
        req_a[32*i +: 32] = $urandom;
        req_b[32*i +: 32] = $urandom;
        req_sub[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drain();
    int k;
    k  = 0;
    en = '0;
    while (k < 300 && !(req_valid == '0 && iq.size() == 0 &&
                        eq.size() == 0 && fcnt < 0)) begin
      step();
      k++;
    end
    if (k >= 300) fail("drain_timeout");
    repeat (3) step();
  endtask

  task automatic put(input int i, input logic [31:0] a,
                     input logic [31:0] b, input logic s);
    req_valid[i] = 1'b1;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i] = s;
  endtask

  initial begin
    int k, g0, r0, s0;
    for (int i = 0; i < N; i++) begin
      hs_cnt[i] = 0;
      seen[i]   = 0;
    end
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    en = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_fu_start", 32'(fu_start), 32'd0);
    chk("rst_fu_a", fu_a, 32'd0);
    chk("rst_fu_b", fu_b, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // All requesters held: strict rotation from index 0.
    en = '1;
    hold = 1;
    lat_rand = 1;
    k = 0;
    while (k < 400 && glog.size() < 5) begin
      step();
      k++;
    end
    if (glog.size() < 5) begin
      fail("rotation_timeout");
    end else begin
      chk("rot0", glog[0], 0);
      chk("rot1", glog[1], 1);
      chk("rot2", glog[2], 2);
      chk("rot3", glog[3], 3);
      chk("rot4", glog[4], 0);
    end

    // Random traffic.
    hold = 0;
    repeat (300) step();
    drain();

    // Single held requester, fixed 3-cycle unit.
    rcyc.delete();
    en = 4'b0010;
    hold = 1;
    lat_rand = 0;
    lat = 3;
    k = 0;
    while (k < 200 && rcyc.size() < 4) begin
      step();
      k++;
    end
    if (rcyc.size() < 4) begin
      fail("single_timeout");
    end else begin
      chk("space1", rcyc[1] - rcyc[0], 7);
      chk("space2", rcyc[2] - rcyc[1], 7);
      chk("space3", rcyc[3] - rcyc[2], 7);
    end
    hold = 0;
    drain();

    // Directed subtraction on requester 2.
    lat = 2;
    put(2, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    drain();
    chk("sub_fu_b", last_fb, 32'hBF80_0000);
    chk("sub_rsp_valid", 32'(last_rv), 32'h4);
    chk("sub_rsp_data", last_rd, 32'h4000_0000);

    // Reset during WAIT; stray completion afterwards.
    lat = 6;
    s0 = st_n;
    put(3, $urandom, $urandom, 1'b0);
    k = 0;
    while (k < 20 && st_n == s0) begin
      step();
      k++;
    end
    if (st_n == s0) fail("wait_timeout");
    rst = 1'b1;
    step();
    step();
    req_valid = '0;
    iq.delete();
    eq.delete();
    rst = 1'b0;
    r0 = rsp_n;
    repeat (10) step();
    chk("rst_no_rsp", rsp_n, r0);
    g0 = glog.size();
    lat = 1;
    put(2, $urandom, $urandom, 1'b1);
    put(0, $urandom, $urandom, 1'b0);
    drain();
    if (glog.size() <= g0) fail("post_rst_grant");
    else chk("post_rst_first", glog[g0], 0);

    // fu_done while idle.
    r0 = rsp_n;
    kick_req++;
    repeat (4) begin
      step();
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_rsp", 32'(rsp_valid), 32'd0);
      chk("idle_start", 32'(fu_start), 32'd0);
    end
    chk("idle_rsp_cnt", rsp_n, r0);

`ifdef FP_ARB_TIMEOUT_EN
    // Unit never answers: abort with canonical NaN.
    mute = 1;
    put(1, $urandom, $urandom, 1'b0);
    drain();
    chk("tmo_err", 32'(last_re), 32'd1);
    chk("tmo_data", last_rd, 32'h7FC0_0000);
    mute = 0;
`endif

    chk("iq_empty", iq.size(), 0);
    chk("eq_empty", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_arbiter.md
FP_ADDSUB_ARBITER -- requirements
Module: fp_addsub_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one FP add/sub unit (legal range 2..8).
REQ-002 Parameter TIMEOUT, default 32, maximum cycles from fu_start to fu_done before abort (legal range 4..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; rst is synchronous, active-high.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  one-hot grant; operands accepted on valid&ready.
REQ-007 req_a  input  32*NREQ  operand A per requester, IEEE-754 single; slice i is bits [32i+31:32i].
REQ-008 req_b  input  32*NREQ  operand B per requester.
REQ-009 req_sub  input  NREQ  1 = A-B, 0 = A+B.
REQ-010 rsp_valid  output  NREQ  one-cycle one-hot pulse to the owner of the completed operation.
REQ-011 rsp_data  output  32  result, valid only while any rsp_valid bit is high.
REQ-012 rsp_err  output  1  high with rsp_valid when the operation was aborted by timeout.
REQ-013 fu_start  output  1  one-cycle launch pulse to the FP unit.
REQ-014 fu_a, fu_b  output  32 each  operands to the FP unit, held stable from fu_start until fu_done.
REQ-015 fu_done  input  1  one-cycle completion pulse from the FP unit.
REQ-016 fu_result  input  32  FP unit result, sampled on fu_done.

Function
REQ-017 FSM states are IDLE, ISSUE, WAIT and RESP; at most one operation is outstanding.
REQ-018 IDLE: when any req_valid bit is set, the block selects the winner round-robin, starting the search at the index after last_grant, and moves to ISSUE.
REQ-019 ISSUE: req_ready for the winner only is high for exactly one cycle; operands latch; fu_start pulses in the next cycle; the FSM enters WAIT.
REQ-020 Subtraction: fu_b = {~b[31], b[30:0]}; fu_a = a unchanged; NaN payloads are not otherwise altered.
REQ-021 WAIT: fu_done latches fu_result and moves the FSM to RESP; fu_done in any other state is ignored.
REQ-022 RESP: rsp_valid[owner] is high for one cycle with rsp_data; the FSM returns to IDLE and last_grant updates to the owner.
REQ-023 Minimum request-to-response latency is 4 cycles plus unit latency; back-to-back grants are separated by at least 4 cycles.
REQ-024 Deassertion of req_valid before the grant withdraws the request without side effects; deassertion after the grant does not cancel the operation.
REQ-025 Requester indices that are not granted observe req_ready = 0 and rsp_valid = 0 at all times.
REQ-026 If fu_done arrives in the same cycle as the fu_start pulse, the block treats it as completion (zero-latency unit).

Reset
REQ-027 While rst is high at a clock edge: the FSM goes to IDLE, last_grant = NREQ-1 (so index 0 wins first), and req_ready, rsp_valid, rsp_err and fu_start are 0.
REQ-028 While rst is high, rsp_data, fu_a and fu_b are 0.
REQ-029 Reset mid-operation drops the in-flight operation silently; a later stray fu_done is ignored.

Configuration
REQ-030 When FP_ARB_TIMEOUT_EN is defined, a cycle counter runs in WAIT. On reaching TIMEOUT, the FSM goes to RESP with rsp_data = 32'h7FC00000 and rsp_err = 1.
REQ-031 When FP_ARB_TIMEOUT_EN is undefined, there is no counter, WAIT lasts until fu_done, and rsp_err is tied to 0.

Verification
REQ-032 After reset, req_valid = 4'b1111 held -> grants in order 0,1,2,3,0; each rsp_valid goes to the matching index.
REQ-033 Requester 2: A = 0x40400000, B = 0x3F800000, sub = 1 -> fu_b = 0xBF800000; unit returns 0x40000000 -> rsp_valid = 4'b0100, rsp_data = 0x40000000.
REQ-034 Single requester 1 held continuously with a 3-cycle unit -> one grant per operation, no duplicate rsp_valid, responses spaced 7 cycles apart.
REQ-035 rst asserted during WAIT, then fu_done pulsed -> no rsp_valid; the next request is granted to index 0.
REQ-036 FP_ARB_TIMEOUT_EN defined, TIMEOUT = 8, fu_done never asserted -> rsp_valid pulses 8 cycles after fu_start with rsp_err = 1 and rsp_data = 0x7FC00000.
REQ-037 fu_done pulsed in IDLE with no request pending -> no output change.
